// File: rtl/maxpool_pair_serializer.sv
// Pairs consecutive samples A,B into {B,A} per channel and streams each pair LSB-chunk first.
// Optional MAXPOOL_SER_FLUSH_EN adds flush_in, which pairs a lone A with the most-negative B.
module maxpool_pair_serializer #(
    parameter int unsigned NO_CH  = 10,
    parameter int unsigned BW_IN  = 12,
    parameter int unsigned SER_BW = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vld_in,
    output logic                      rdy_in,
    input  logic [NO_CH*BW_IN-1:0]    data_in,
`ifdef MAXPOOL_SER_FLUSH_EN
    input  logic                      flush_in,
`endif
    output logic                      vld_out,
    output logic [NO_CH*SER_BW-1:0]   data_out
);

    localparam int unsigned PAIR_W  = 2 * BW_IN;
    localparam int unsigned BUF_CYC = PAIR_W / SER_BW;
    localparam int unsigned CNT_W   = (BUF_CYC > 1) ? $clog2(BUF_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BUF_CYC - 1);

    generate
        if (!((SER_BW == PAIR_W) ||
              ((SER_BW > 0) && (SER_BW <= BW_IN) && ((PAIR_W % SER_BW) == 0)))) begin : g_bad_ser_bw
            $error("maxpool_pair_serializer: illegal SER_BW");
        end
    endgenerate

    logic                      r_a_full;
    logic                      r_busy;
    logic [CNT_W-1:0]          r_cnt;
    logic [NO_CH*BW_IN-1:0]    r_hold;
    logic [NO_CH*PAIR_W-1:0]   r_shift;
    logic [NO_CH*SER_BW-1:0]   r_data_out;

    logic                      w_last;
    logic                      w_hs;
    logic                      w_a_hs;
    logic                      w_b_hs;
    logic                      w_flush;
    logic                      w_load;
    logic [NO_CH*BW_IN-1:0]    w_b_src;
    logic [NO_CH*PAIR_W-1:0]   w_pair;
    logic [NO_CH*PAIR_W-1:0]   w_shift_nxt;
    logic                      w_busy_nxt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [NO_CH*SER_BW-1:0]   w_beat_nxt;

    // The shifter can take a new pair when idle or on its final beat.
    assign rdy_in = !r_a_full || !r_busy || (r_cnt == LAST_CNT);
    assign w_last = r_busy && (r_cnt == LAST_CNT);
    assign w_hs   = vld_in && rdy_in;
    assign w_a_hs = w_hs && !r_a_full;
    assign w_b_hs = w_hs && r_a_full;

`ifdef MAXPOOL_SER_FLUSH_EN
    localparam logic [BW_IN-1:0] MOST_NEG = BW_IN'(1) << (BW_IN - 1);
    logic r_flush_pend;
    logic w_flush_req;

    assign w_flush_req = flush_in || r_flush_pend;
    assign w_flush     = w_flush_req && r_a_full && rdy_in && !w_hs;
    assign w_b_src     = w_b_hs ? data_in : {NO_CH{MOST_NEG}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_pend <= 1'b0;
        end else begin
            r_flush_pend <= w_flush_req && r_a_full && !w_load;
        end
    end
`else
    assign w_flush = 1'b0;
    assign w_b_src = data_in;
`endif

    assign w_load = w_b_hs || w_flush;

    // Next shifter/beat state; the output chunk is registered from these.
    always_comb begin
        w_pair      = '0;
        w_beat_nxt  = '0;
        w_busy_nxt  = r_busy;
        w_cnt_nxt   = '0;
        for (int ch = 0; ch < int'(NO_CH); ch++) begin
            w_pair[ch*PAIR_W +: PAIR_W] = {w_b_src[ch*BW_IN +: BW_IN], r_hold[ch*BW_IN +: BW_IN]};
        end
        w_shift_nxt = w_load ? w_pair : r_shift;
        if (w_load) begin
            w_busy_nxt = 1'b1;
            w_cnt_nxt  = '0;
        end else if (w_last) begin
            w_busy_nxt = 1'b0;
            w_cnt_nxt  = '0;
        end else if (r_busy) begin
            w_cnt_nxt  = r_cnt + CNT_W'(1);
        end
        if (w_busy_nxt) begin
            for (int ch = 0; ch < int'(NO_CH); ch++) begin
                w_beat_nxt[ch*SER_BW +: SER_BW] =
                    w_shift_nxt[ch*PAIR_W + int'(w_cnt_nxt)*SER_BW +: SER_BW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_full   <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_shift    <= '0;
            r_data_out <= '0;
        end else begin
            if (w_a_hs) begin
                r_a_full <= 1'b1;
                r_hold   <= data_in;
            end else if (w_load) begin
                r_a_full <= 1'b0;
            end
            r_busy     <= w_busy_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_data_out <= w_beat_nxt;
        end
    end

    assign vld_out  = r_busy;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_maxpool_pair_serializer.sv
// Directed bench for maxpool_pair_serializer (NO_CH=2, BW_IN=12, SER_BW=4 and SER_BW=24 instances).
// Define MAXPOOL_SER_FLUSH_EN to also exercise flush_in.
module tb_maxpool_pair_serializer;

    localparam int NO_CH  = 2;
    localparam int BW_IN  = 12;
    localparam int SER_BW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_in;
    logic        rdy_in;
    logic [23:0] data_in;
    logic        vld_out;
    logic [7:0]  data_out;

    logic        vld_in24;
    logic        rdy_in24;
    logic [23:0] data_in24;
    logic        vld_out24;
    logic [47:0] data_out24;

`ifdef MAXPOOL_SER_FLUSH_EN
    logic        flush_in;
    logic        flush_in24;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    maxpool_pair_serializer #(.NO_CH(NO_CH), .BW_IN(BW_IN), .SER_BW(SER_BW)) u_dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy_in), .data_in(data_in),
`ifdef MAXPOOL_SER_FLUSH_EN
        .flush_in(flush_in),
`endif
        .vld_out(vld_out), .data_out(data_out)
    );

    maxpool_pair_serializer #(.NO_CH(NO_CH), .BW_IN(BW_IN), .SER_BW(24)) u_dut24 (
        .clk(clk), .rst(rst), .vld_in(vld_in24), .rdy_in(rdy_in24), .data_in(data_in24),
`ifdef MAXPOOL_SER_FLUSH_EN
        .flush_in(flush_in24),
`endif
        .vld_out(vld_out24), .data_out(data_out24)
    );

    function automatic logic [23:0] sample(input int k);
        logic [11:0] c0;
        logic [11:0] c1;
        c0 = 12'(32'h100 + k);
        c1 = 12'(32'h200 + k);
        return {c1, c0};
    endfunction

    // Expected chunk of pair {b,a} for a given beat, both channels.
    function automatic logic [7:0] exp_beat(input logic [23:0] a, input logic [23:0] b, input int beat);
        logic [23:0] pair;
        logic [7:0]  e;
        e = '0;
        for (int ch = 0; ch < NO_CH; ch++) begin
            pair = {b[ch*12 +: 12], a[ch*12 +: 12]};
            e[ch*4 +: 4] = 4'(pair >> (4 * beat));
        end
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vld_in = 1'b0;
        vld_in24 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (vld_out !== 1'b0 || data_out !== 8'h00) $display("FAIL reset_out: vld=%b data=%h want vld=0 data=00", vld_out, data_out);
        else passed++;
        total++;
        if (rdy_in !== 1'b1) $display("FAIL reset_rdy: got %b want 1", rdy_in);
        else passed++;
        total++;
        if (vld_out24 !== 1'b0 || data_out24 !== 48'h0) $display("FAIL reset_out24: vld=%b data=%h want 0", vld_out24, data_out24);
        else passed++;
    endtask

    task automatic test_single_pair();
        logic [7:0] exp [6] = '{8'h03, 8'h02, 8'h81, 8'hFC, 8'hFB, 8'h7A};
        do_reset();
        @(negedge clk);
        vld_in = 1'b1;
        data_in = {12'h800, 12'h123};
        @(negedge clk);
        total++;
        if (rdy_in !== 1'b1 || vld_out !== 1'b0) $display("FAIL single_after_a: rdy=%b vld=%b want rdy=1 vld=0", rdy_in, vld_out);
        else passed++;
        data_in = {12'h7FF, 12'hABC};
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            vld_in = 1'b0;
            data_in = 24'hFFFFFF;
            total++;
            if (vld_out !== 1'b1 || data_out !== exp[b])
                $display("FAIL single_beat%0d: vld=%b data=%h want vld=1 data=%h", b, vld_out, data_out, exp[b]);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (vld_out !== 1'b0 || data_out !== 8'h00) $display("FAIL single_end: vld=%b data=%h want vld=0 data=00", vld_out, data_out);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        logic exp_rdy;
        logic exp_vld;
        logic [7:0] exp_d;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            exp_rdy = (c <= 2) || (c == 7) || (c == 8) || (c == 13);
            exp_vld = (c >= 2);
            if (c >= 2 && c <= 7) exp_d = exp_beat(sample(0), sample(1), c - 2);
            else if (c >= 8) exp_d = exp_beat(sample(2), sample(3), c - 8);
            else exp_d = 8'h00;
            total++;
            if (rdy_in !== exp_rdy) $display("FAIL b2b_rdy c%0d: got %b want %b", c, rdy_in, exp_rdy);
            else passed++;
            total++;
            if (vld_out !== exp_vld || data_out !== exp_d)
                $display("FAIL b2b_out c%0d: vld=%b data=%h want vld=%b data=%h", c, vld_out, data_out, exp_vld, exp_d);
            else passed++;
            vld_in = 1'b1;
            data_in = sample(acc);
            if (rdy_in) acc++;
        end
        @(negedge clk);
        vld_in = 1'b0;
        total++;
        if (acc !== 6) $display("FAIL b2b_accepts: got %0d want 6", acc);
        else passed++;
    endtask

    task automatic test_idle_gaps();
        int beats = 0;
        int rdy_low = 0;
        logic exp_vld;
        logic [7:0] exp_d;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rdy_in !== 1'b1) rdy_low++;
            exp_vld = (c >= 11 && c <= 16) || (c >= 31 && c <= 36);
            if (c >= 11 && c <= 16) exp_d = exp_beat(sample(10), sample(11), c - 11);
            else if (c >= 31 && c <= 36) exp_d = exp_beat(sample(12), sample(13), c - 31);
            else exp_d = 8'h00;
            if (vld_out === 1'b1) beats++;
            total++;
            if (vld_out !== exp_vld || data_out !== exp_d)
                $display("FAIL gaps_out c%0d: vld=%b data=%h want vld=%b data=%h", c, vld_out, data_out, exp_vld, exp_d);
            else passed++;
            vld_in = ((c % 10) == 0);
            data_in = ((c % 10) == 0) ? sample(10 + c / 10) : 24'hFFFFFF;
        end
        vld_in = 1'b0;
        total++;
        if (rdy_low !== 0) $display("FAIL gaps_rdy: rdy low %0d cycles want 0", rdy_low);
        else passed++;
        total++;
        if (beats !== 12) $display("FAIL gaps_beats: got %0d want 12", beats);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        do_reset();
        @(negedge clk);
        vld_in = 1'b1; data_in = sample(20);
        @(negedge clk);
        data_in = sample(21);
        @(negedge clk);
        data_in = sample(22);
        @(negedge clk);
        vld_in = 1'b0; data_in = 24'hFFFFFF;
        @(negedge clk);
        @(negedge clk);
        e = exp_beat(sample(20), sample(21), 3);
        total++;
        if (vld_out !== 1'b1 || data_out !== e) $display("FAIL mid_beat3: vld=%b data=%h want vld=1 data=%h", vld_out, data_out, e);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (vld_out !== 1'b0 || data_out !== 8'h00 || rdy_in !== 1'b1)
            $display("FAIL mid_after_rst: vld=%b data=%h rdy=%b want 0 00 1", vld_out, data_out, rdy_in);
        else passed++;
        vld_in = 1'b1; data_in = sample(30);
        @(negedge clk);
        total++;
        if (vld_out !== 1'b0) $display("FAIL mid_stale: vld=%b want 0", vld_out);
        else passed++;
        data_in = sample(31);
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            vld_in = 1'b0; data_in = 24'hFFFFFF;
            e = exp_beat(sample(30), sample(31), b);
            total++;
            if (vld_out !== 1'b1 || data_out !== e)
                $display("FAIL mid_new_beat%0d: vld=%b data=%h want vld=1 data=%h", b, vld_out, data_out, e);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (vld_out !== 1'b0) $display("FAIL mid_end: vld=%b want 0", vld_out);
        else passed++;
    endtask

    task automatic test_wide();
        do_reset();
        @(negedge clk);
        vld_in24 = 1'b1; data_in24 = 24'h001001;
        @(negedge clk);
        total++;
        if (rdy_in24 !== 1'b1 || vld_out24 !== 1'b0) $display("FAIL wide_after_a: rdy=%b vld=%b want 1 0", rdy_in24, vld_out24);
        else passed++;
        data_in24 = 24'hFFFFFF;
        @(negedge clk);
        vld_in24 = 1'b0;
        total++;
        if (vld_out24 !== 1'b1 || data_out24 !== 48'hFFF001FFF001 || rdy_in24 !== 1'b1)
            $display("FAIL wide_beat: vld=%b data=%h rdy=%b want 1 fff001fff001 1", vld_out24, data_out24, rdy_in24);
        else passed++;
        @(negedge clk);
        total++;
        if (vld_out24 !== 1'b0) $display("FAIL wide_end: vld=%b want 0", vld_out24);
        else passed++;
    endtask

`ifdef MAXPOOL_SER_FLUSH_EN
    task automatic test_flush();
        logic [7:0] exp [6] = '{8'h55, 8'h44, 8'h33, 8'h00, 8'h00, 8'h88};
        int stray = 0;
        do_reset();
        @(negedge clk);
        vld_in = 1'b1; data_in = {12'h345, 12'h345};
        @(negedge clk);
        vld_in = 1'b0; data_in = 24'hFFFFFF; flush_in = 1'b1;
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            flush_in = 1'b0;
            total++;
            if (vld_out !== 1'b1 || data_out !== exp[b])
                $display("FAIL flush_beat%0d: vld=%b data=%h want vld=1 data=%h", b, vld_out, data_out, exp[b]);
            else passed++;
        end
        @(negedge clk);
        flush_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            flush_in = 1'b0;
            if (vld_out !== 1'b0) stray++;
        end
        total++;
        if (stray !== 0) $display("FAIL flush_empty: %0d valid beats want 0", stray);
        else passed++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        vld_in = 1'b0;
        data_in = '0;
        vld_in24 = 1'b0;
        data_in24 = '0;
`ifdef MAXPOOL_SER_FLUSH_EN
        flush_in = 1'b0;
        flush_in24 = 1'b0;
`endif
        test_reset();
        test_single_pair();
        test_back_to_back();
        test_idle_gaps();
        test_reset_mid();
        test_wide();
`ifdef MAXPOOL_SER_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
